pll_lock_reset_seq: RTL
=======================

Name: pll_lock_reset_seq

Overview:
Reset sequencer that sits directly downstream of the 50 MHz→100 MHz system PLL wrapper.
- Runs on the free-running reference clock.
- Drives the PLL's reset input and consumes its asynchronous locked output.
- Releases the system reset only after lock has been continuously stable for a programmable time.
- Re-resets the PLL on lock timeout, on loss of lock, or on software request, and keeps error/loss statistics.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchronizer (min 2)
PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per PLL reset pulse (min 2)
LOCK_TIMEOUT_CYCLES, 65536, max refclk cycles spent in WAIT_LOCK before PLL reset is retried (min 2)
LOCK_STABLE_CYCLES, 1024, consecutive cycles locked must stay high before sys_rst releases (min 2)
CNT_W, 8, width of the saturating lock-loss counter

Ports:
refclk  input  1  block clock (PLL reference, always running)
rst  input  1  synchronous active-high reset
pll_locked  input  1  PLL locked output, asynchronous to refclk
force_relock  input  1  single-cycle request to re-lock the PLL
pll_rst  output  1  reset to the PLL rst input, active-high
sys_rst  output  1  reset to logic in PLL output domains, active-high
ready  output  1  high while the PLL is locked and stable
timeout_err  output  1  sticky; a WAIT_LOCK timeout has occurred
lock_lost_cnt  output  CNT_W  saturating count of lock losses seen in RUN
state_o  output  2  current state encoding, for debug

Behaviour:
- One clock, refclk. rst is synchronous and active-high; all flops, including the synchronizer, clear on it.
- Reset values: state PLL_RESET; pll_rst 1; sys_rst 1; ready 0; timeout_err 0; lock_lost_cnt 0; cycle counter 0; synchronizer all 0.
- pll_locked passes through SYNC_STAGES flops to give locked_s. The FSM sees only locked_s.
- Outputs are registered and are a pure decode of the state register. There is no combinational path from any input to any output.
  - pll_rst = (state==PLL_RESET)
  - sys_rst = (state!=RUN)
  - ready = (state==RUN)
  - state_o encoding: PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.
- A single cycle counter, sized to the largest of the three cycle parameters, clears on every state change.
- PLL_RESET:
  - Stays exactly PLL_RST_CYCLES cycles, then moves to WAIT_LOCK.
  - locked_s and force_relock are ignored.
- WAIT_LOCK:
  - locked_s=1 → STABILIZE.
  - Otherwise, once the counter reaches LOCK_TIMEOUT_CYCLES-1: set timeout_err and go to PLL_RESET. WAIT_LOCK therefore lasts at most LOCK_TIMEOUT_CYCLES cycles.
- STABILIZE:
  - locked_s=0 → WAIT_LOCK. The counter restarts and lock_lost_cnt does not change.
  - locked_s high for LOCK_STABLE_CYCLES consecutive cycles (counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1) → RUN.
- RUN:
  - locked_s=0 → PLL_RESET, and lock_lost_cnt increments.
  - lock_lost_cnt saturates at 2^CNT_W-1.
- force_relock=1 in WAIT_LOCK, STABILIZE or RUN → PLL_RESET on the next edge.
  - force_relock has priority over all other transitions.
  - If it coincides with locked_s=0 in RUN, lock_lost_cnt still increments.
  - If it coincides with a WAIT_LOCK timeout, timeout_err still sets.
- timeout_err clears only on rst.
- rst asserted in any state:
  - Next edge returns to reset values.
  - sys_rst is high immediately from that edge, so downstream logic must never see ready=1 during rst.
- Latency with pll_locked held high from time 0: sys_rst falls PLL_RST_CYCLES + 1 + LOCK_STABLE_CYCLES cycles after the first cycle with rst=0. The synchronizer fills during PLL_RESET, given PLL_RST_CYCLES ≥ SYNC_STAGES.
- Loss-to-reset latency: pll_locked falling in RUN makes sys_rst rise SYNC_STAGES+1 edges later.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, SYNC_STAGES=2, CNT_W=8.
1. Power-up, clean lock: rst for 3 cycles, then pll_locked=1 constant → pll_rst high for cycles 0-3 after rst release; sys_rst falls and ready rises at cycle 13; timeout_err=0; lock_lost_cnt=0.
2. No lock: pll_locked=0 forever → pattern repeats every 36 cycles (pll_rst high 4, low 32); timeout_err rises at the first timeout and stays 1; sys_rst is never released.
3. Glitchy lock: pll_locked drops low for 1 cycle, 5 cycles into STABILIZE → FSM returns to WAIT_LOCK then restarts STABILIZE; ready rises 8 cycles after the last re-lock; lock_lost_cnt=0.
4. Loss in RUN: from RUN, drop pll_locked → sys_rst rises 3 edges later with state_o=0 and lock_lost_cnt=1; repeat 260 times → lock_lost_cnt saturates at 255.
5. force_relock: a pulse in RUN → PLL_RESET next edge with pll_rst=1 and lock_lost_cnt unchanged; a pulse during PLL_RESET → no effect, the 4-cycle pulse is not extended.
6. Mid-operation reset: rst asserted while in STABILIZE and while in RUN → next edge: pll_rst=1, sys_rst=1, ready=0, timeout_err=0, lock_lost_cnt=0, state_o=0.

Source files
------------

// File: rtl/pll_lock_reset_seq_if.sv
// Handshake bundle between the PLL wrapper/system side and the lock/reset sequencer.
// master drives the PLL status and relock request; slave is the sequencer.
interface pll_lock_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             force_relock;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic             timeout_err;
  logic [CNT_W-1:0] lock_lost_cnt;
  logic [1:0]       state_o;

  modport master (
    output pll_locked, force_relock,
    input  pll_rst, sys_rst, ready, timeout_err, lock_lost_cnt, state_o
  );

  modport slave (
    input  pll_locked, force_relock,
    output pll_rst, sys_rst, ready, timeout_err, lock_lost_cnt, state_o
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL reset sequencer on refclk: pulses the PLL reset, waits for a stable lock, then releases sys_rst.
// Outputs decode registered state only; no combinational input-to-output path.
module pll_lock_reset_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_lock_reset_seq_if.slave  bus
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CTR_W = (MAX_C > 2) ? $clog2(MAX_C) : 1;

  localparam logic [CTR_W-1:0] RST_LAST = CTR_W'(PLL_RST_CYCLES - 1);
  localparam logic [CTR_W-1:0] TO_LAST  = CTR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CTR_W-1:0] STB_LAST = CTR_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABILIZE = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CTR_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic                   locked_s;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ST_PLL_RESET;
      cnt_q   <= '0;
      sync_q  <= '0;
      err_q   <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      err_q   <= err_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    loss_d  = loss_q;
    cnt_d   = (cnt_q != '1) ? cnt_q + CTR_W'(1) : cnt_q;
    unique case (state_q)
      ST_PLL_RESET: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A timeout is recorded even when a relock request wins the transition.
        if (!locked_s && cnt_q == TO_LAST) err_d = 1'b1;
        if (bus.force_relock)             state_d = ST_PLL_RESET;
        else if (locked_s)                state_d = ST_STABILIZE;
        else if (cnt_q == TO_LAST)        state_d = ST_PLL_RESET;
      end
      ST_STABILIZE: begin
        if (bus.force_relock)             state_d = ST_PLL_RESET;
        else if (!locked_s)               state_d = ST_WAIT_LOCK;
        else if (cnt_q == STB_LAST)       state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s && loss_q != '1) loss_d = loss_q + CNT_W'(1);
        if (bus.force_relock || !locked_s) state_d = ST_PLL_RESET;
      end
      default: state_d = ST_PLL_RESET;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign bus.pll_rst       = (state_q == ST_PLL_RESET);
  assign bus.sys_rst       = (state_q != ST_RUN);
  assign bus.ready         = (state_q == ST_RUN);
  assign bus.timeout_err   = err_q;
  assign bus.lock_lost_cnt = loss_q;
  assign bus.state_o       = state_q;

endmodule
